// File: rtl/fixed_square_if.sv
// Request/result bundle for the iterative fixed-point squarer.
// The master side issues start/x_in and watches busy; the slave side
// (the squarer) owns the registered result outputs.
interface fixed_square_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] x_in;
    logic             busy;
    logic             valid_out;
    logic [WIDTH-1:0] x_out;
    logic             ovf;

    modport master (
        output start,
        output x_in,
        input  busy,
        input  valid_out,
        input  x_out,
        input  ovf
    );

    modport slave (
        input  start,
        input  x_in,
        output busy,
        output valid_out,
        output x_out,
        output ovf
    );
endinterface

// File: rtl/fixed_square.sv
// Iterative fixed-point squarer: x_out = round(x_in^2) in the same Q format.
// One shift-and-add step per cycle on |x_in|, then a round-half-up step
// with saturation to the largest positive value. Result is always >= 0.
// Defaults match the math library's WIDTH/Q_BITS settings (Q_BITS >= 1).
module fixed_square #(
    parameter int WIDTH  = 16,
    parameter int Q_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    fixed_square_if.slave bus
);

    // Full-precision product width, plus one guard bit so the rounding
    // bias can never carry out of the sum.
    localparam int ACC_W = 2 * WIDTH;
    localparam int SUM_W = ACC_W + 1;
    localparam int R_W   = SUM_W - Q_BITS;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [CNT_W-1:0] LAST_ITER  = CNT_W'(WIDTH - 1);
    localparam logic [SUM_W-1:0] ROUND_BIAS = SUM_W'(1) << (Q_BITS - 1);
    localparam logic [WIDTH-1:0] MAX_POS    = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ROUND
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] multiplicand;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] multiplier;
    logic [CNT_W-1:0] bit_cnt;

    logic [WIDTH-1:0] x_mag;
    logic [R_W-1:0]   round_q;
    logic             sat;

    // Magnitude of the operand. The most negative input negates to itself,
    // which read as unsigned is exactly 2^(WIDTH-1), so no wrap occurs.
    always_comb begin
        x_mag = bus.x_in;
        if (bus.x_in[WIDTH-1]) begin
            x_mag = ~bus.x_in + WIDTH'(1);
        end
    end

    // Round half up on the full product and drop the extra fraction bits;
    // anything at or above 2^(WIDTH-1) no longer fits a positive result.
    assign round_q = R_W'(({1'b0, acc} + ROUND_BIAS) >> Q_BITS);
    assign sat     = |round_q[R_W-1:WIDTH-1];

    // Control FSM and datapath; every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            multiplicand  <= '0;
            multiplier    <= '0;
            acc           <= '0;
            bit_cnt       <= '0;
            bus.busy      <= 1'b0;
            bus.valid_out <= 1'b0;
            bus.x_out     <= '0;
            bus.ovf       <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        multiplicand <= ACC_W'(x_mag);
                        multiplier   <= x_mag;
                        acc          <= '0;
                        bit_cnt      <= '0;
                        bus.busy     <= 1'b1;
                        state        <= MUL;
                    end
                end
                MUL: begin
                    if (multiplier[0]) begin
                        acc <= acc + multiplicand;
                    end
                    multiplicand <= multiplicand << 1;
                    multiplier   <= multiplier >> 1;
                    bit_cnt      <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_ITER) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (sat) begin
                        bus.x_out <= MAX_POS;
                        bus.ovf   <= 1'b1;
                    end else begin
                        bus.x_out <= {1'b0, round_q[WIDTH-2:0]};
                        bus.ovf   <= 1'b0;
                    end
                    bus.valid_out <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fixed_square.md
# fixed_square

Iterative fixed-point squarer. Computes x_in² for a signed Q-format operand. Sits alongside the CORDIC square-root unit in the math library so the ray pipeline can go both ways between a length and its square (e.g. re-squaring a computed distance, checking a sqrt result). Uses a shift-and-add core with one bit per cycle, rounds to nearest, and saturates. It needs no vendor IP.

## Interface
- WIDTH, default `WIDTH` (Types.sv): operand and result width, two's complement.
- Q_BITS, default `Q_BITS` (Types.sv): fractional bits of operand and result.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- x_in  in  WIDTH  signed Q operand. Captured in the cycle start is accepted.
- busy  out  1  high while an operation is in flight (MUL or ROUND).
- valid_out  out  1  one-cycle pulse: x_out/ovf hold a new result.
- x_out  out  WIDTH  result, always ≥ 0. Holds until the next result.
- ovf  out  1  result saturated. Valid with and held alongside x_out.

## Operation
- States:
  - IDLE: start=1 → capture |x_in| into multiplicand and multiplier registers, clear accumulator (2·WIDTH bits) and bit counter, go to MUL. start=0 → stay.
  - MUL: each cycle, if multiplier LSB=1, add multiplicand to accumulator. Then shift multiplicand left 1, multiplier right 1, counter+1. After WIDTH iterations → ROUND.
  - ROUND: r = (acc + 2^(Q_BITS-1)) >> Q_BITS (round half up, unsigned). If r > 2^(WIDTH-1)-1: x_out ← 2^(WIDTH-1)-1 and ovf ← 1. Else x_out ← r[WIDTH-1:0] and ovf ← 0. Set valid_out, → IDLE.
- Magnitude: |x| = x when x ≥ 0, else −x. The most negative input, −2^(WIDTH-1), gives magnitude 2^(WIDTH-1), held in WIDTH unsigned bits with no wrap.
- Accumulator is 2·WIDTH bits; the rounding add must not overflow. Widen by 1 bit internally if needed.
- start while busy=1 is ignored; x_in is not re-captured.
- Reset: state IDLE, busy 0, valid_out 0, x_out 0, ovf 0. Reset mid-operation aborts the operation; no valid_out follows.
- Reset and start in the same cycle: reset wins.

## Timing
- Cycle 0: start=1 sampled in IDLE.
- Cycles 1..WIDTH: MUL, busy=1.
- Cycle WIDTH+1: ROUND, busy=1.
- Cycle WIDTH+2: valid_out=1 for this cycle only, busy=0, state IDLE. Latency is WIDTH+2 cycles from start to valid_out.
- A new start may be accepted in the cycle valid_out is high. Back-to-back throughput is one result per WIDTH+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Bench uses WIDTH=16, Q_BITS=8.
- Reset, then idle 5 cycles → busy=0, valid_out=0, x_out=0x0000, ovf=0.
- x_in=0x0180 (1.5), start 1 cycle → valid_out exactly in cycle 18 after start, x_out=0x0240 (2.25), ovf=0. Then x_in=0xFE00 (−2.0) → x_out=0x0400, ovf=0.
- Rounding:
  - x_in=0x000C → 144/65536 rounds to x_out=0x0001.
  - x_in=0x000B → 121/65536 rounds to x_out=0x0000.
  - x_in=0x0010 → x_out=0x0001 exactly.
- Saturation:
  - x_in=0x1000 (16.0) → x_out=0x7FFF, ovf=1.
  - x_in=0x8000 → x_out=0x7FFF, ovf=1.
  - A following x_in=0x0100 → x_out=0x0100, ovf=0.
- Pulse start again in cycles 3 and 10 of an operation on 0x0180 with x_in=0x1000 → single result 0x0240, no extra valid_out. A start in the valid_out cycle is accepted, and its result follows 18 cycles later.
- Assert rst in cycle 8 of an operation, then release → busy=0, valid_out never pulses, x_out=0. A new start after reset yields the correct result.
